// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// instruction fetch and the MEM-stage load/store path. Each access is issued
// from IDLE, waits for mem_ready, and returns a one-cycle completion pulse with
// registered read data. Store lanes and load extension are formatted here.
// Optional feature: define MEM_ARB_WATCHDOG_EN to abort accesses that wait
// TIMEOUT_CYCLES without mem_ready and raise a sticky err.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int FAIR_LIMIT     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [1:0]            d_swhb,
  input  logic [1:0]            d_lwhb,
  input  logic                  d_lunsigned,
  output logic                  d_done,
  output logic [31:0]           d_rdata,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_e;

  localparam logic [3:0] FAIR_MAX = 4'(FAIR_LIMIT);

  state_e                state_q, state_d;
  logic [3:0]            fair_cnt_q, fair_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            lwhb_q, lwhb_d;
  logic                  lunsigned_q, lunsigned_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic                  d_done_q, d_done_d;
  logic [31:0]           d_rdata_q, d_rdata_d;

  logic                  timeout;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_val;

  // Store byte-lane enables and lane-replicated write data from d_swhb.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    st_be    = 4'b0000;
    st_wdata = d_wdata;
    case (d_swhb)
      2'b01: st_be = 4'b1111;
      2'b10: begin
        st_be    = 4'b0011 << {d_addr[1], 1'b0};
        st_wdata = {2{d_wdata[15:0]}};
      end
      2'b11: begin
        st_be    = 4'b0001 << d_addr[1:0];
        st_wdata = {4{d_wdata[7:0]}};
      end
      default: ; // swhb 00: issue with no byte enabled
    endcase
  end

  // Load lane selection and sign/zero extension of the returned word.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lwhb_q)
      2'b01:   ld_val = lunsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      2'b10:   ld_val = lunsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      default: ld_val = mem_rdata; // 00 and 11 are both word loads
    endcase
  end

  // Arbitration, access capture and completion: next-state logic.
  always_comb begin
    state_d     = state_q;
    fair_cnt_d  = fair_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    lane_d      = lane_q;
    lwhb_d      = lwhb_q;
    lunsigned_d = lunsigned_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_done_d    = 1'b0;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        // The completing requester still holds its request during the pulse
        // cycle, so nothing is granted until the pulse has gone.
        if (!if_rvalid_q && !d_done_q) begin
          if (d_req && !(if_req && fair_cnt_q == FAIR_MAX)) begin
            state_d     = S_DATA;
            addr_d      = {d_addr[ADDR_WIDTH-1:2], 2'b00};
            we_d        = d_we;
            be_d        = d_we ? st_be : 4'b1111;
            wdata_d     = d_we ? st_wdata : 32'h0;
            lane_d      = d_addr[1:0];
            lwhb_d      = d_lwhb;
            lunsigned_d = d_lunsigned;
            // Count data grants that made fetch wait; saturate at the limit.
            if (!if_req)                    fair_cnt_d = 4'd0;
            else if (fair_cnt_q < FAIR_MAX) fair_cnt_d = fair_cnt_q + 4'd1;
          end else if (if_req) begin
            state_d    = S_FETCH;
            addr_d     = {if_addr[ADDR_WIDTH-1:2], 2'b00};
            we_d       = 1'b0;
            be_d       = 4'b1111;
            wdata_d    = 32'h0;
            fair_cnt_d = 4'd0;
          end
        end
      end
      S_FETCH, S_DATA: begin
        if (mem_ready || timeout) begin
          state_d = S_IDLE;
          if (state_q == S_FETCH) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_ready ? mem_rdata : 32'h0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = (mem_ready && !we_q) ? ld_val : 32'h0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (reset) begin
      // NOTE: the captured access fields are reset too because they drive ports directly.
      state_q     <= S_IDLE;
      fair_cnt_q  <= 4'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      lane_q      <= 2'd0;
      lwhb_q      <= 2'd0;
      lunsigned_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_done_q    <= 1'b0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      fair_cnt_q  <= fair_cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      lane_q      <= lane_d;
      lwhb_q      <= lwhb_d;
      lunsigned_q <= lunsigned_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_done_q    <= d_done_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q;

  // Wait counter restarts in IDLE, so it is zero in the first busy cycle.
  always_comb begin
    wd_d = (state_q == S_IDLE) ? '0 : wd_q + WD_W'(1);
  end

  assign timeout = (state_q != S_IDLE) && !mem_ready &&
                   (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_q | timeout;
    end
  end

  assign err = err_q;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
  assign err                = 1'b0;
`endif

  assign mem_req   = (state_q != S_IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;

  // A requester stalls unless its completion pulse is due next cycle.
  assign stall_if  = if_req & ~if_rvalid_d;
  assign stall_mem = d_req  & ~d_done_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized
// single-requester accesses checked against a behavioural model.
module tb_mem_port_arbiter;

  localparam int FAIR_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_swhb;
  logic [1:0]  d_lwhb;
  logic        d_lunsigned;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH    (32),
    .FAIR_LIMIT    (FAIR_LIMIT),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_swhb     (d_swhb),
    .d_lwhb     (d_lwhb),
    .d_lunsigned(d_lunsigned),
    .d_done     (d_done),
    .d_rdata    (d_rdata),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  // Behavioural model of one access, from byte-address arithmetic.
  function automatic void model(input bit fetch, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] swhb,
                                input logic [1:0] lwhb, input bit uns, input logic [31:0] word,
                                output logic [31:0] e_addr, output logic [3:0] e_be,
                                output logic [31:0] e_wdata, output bit chk_w,
                                output logic [31:0] e_rdata);
    int unsigned lane, v;
    lane    = addr % 4;
    e_addr  = addr - lane;
    e_be    = 4'hF;
    e_wdata = 32'h0;
    chk_w   = 1'b0;
    e_rdata = 32'h0;
    if (fetch) begin
      e_rdata = word;
    end else if (we) begin
      chk_w = 1'b1;
      case (swhb)
        2'b01: e_wdata = wdata;
        2'b10: begin
          e_be    = 4'(3 << (2 * (lane / 2)));
          e_wdata = (wdata % 65536) * 32'h0001_0001;
        end
        2'b11: begin
          e_be    = 4'(1 << lane);
          e_wdata = (wdata % 256) * 32'h0101_0101;
        end
        default: begin
          e_be  = 4'h0;
          chk_w = 1'b0;
        end
      endcase
    end else begin
      case (lwhb)
        2'b01: begin
          v       = (word >> (16 * (lane / 2))) % 65536;
          e_rdata = (uns || v < 32768) ? v : v + 32'hFFFF_0000;
        end
        2'b10: begin
          v       = (word >> (8 * lane)) % 256;
          e_rdata = (uns || v < 128) ? v : v + 32'hFFFF_FF00;
        end
        default: e_rdata = word;
      endcase
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One single-requester access with lat wait cycles before mem_ready.
  task automatic do_access(input string name, input bit fetch, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] swhb, input logic [1:0] lwhb, input bit uns,
                           input logic [31:0] word, input int lat);
    logic [31:0] e_addr, e_wdata, e_rdata, got_rdata;
    logic [3:0]  e_be;
    bit          chk_w;
    logic        got_pulse, got_stall;
    model(fetch, we, addr, wdata, swhb, lwhb, uns, word, e_addr, e_be, e_wdata, chk_w, e_rdata);
    @(negedge clk);
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      d_swhb = swhb; d_lwhb = lwhb; d_lunsigned = uns;
    end
    mem_ready = 1'b0;
    #1;
    got_stall = fetch ? stall_if : stall_mem;
    checks++;
    if ({mem_req, got_stall} !== 2'b01) begin
      errors++;
      $display("FAIL %s req_cycle mem_req,stall got %b want 01", name, {mem_req, got_stall});
    end
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      mem_ready = (c == lat);
      mem_rdata = (c == lat) ? word : $urandom;
      #1;
      got_stall = fetch ? stall_if : stall_mem;
      got_pulse = fetch ? if_rvalid : d_done;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, we && !fetch, e_addr, e_be}) begin
        errors++;
        $display("FAIL %s issue req=%b we=%b addr=%h be=%b want 1 %b %h %b", name,
                 mem_req, mem_we, mem_addr, mem_be, we && !fetch, e_addr, e_be);
      end
      if (chk_w) begin
        checks++;
        if (mem_wdata !== e_wdata) begin
          errors++;
          $display("FAIL %s wdata got %h want %h", name, mem_wdata, e_wdata);
        end
      end
      checks++;
      if ({got_stall, got_pulse} !== {c != lat, 1'b0}) begin
        errors++;
        $display("FAIL %s busy%0d stall,pulse got %b want %b0", name, c,
                 {got_stall, got_pulse}, c != lat);
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    #1;
    got_pulse = fetch ? if_rvalid : d_done;
    got_rdata = fetch ? if_rdata : d_rdata;
    checks++;
    if ({got_pulse, mem_req} !== 2'b10 || got_rdata !== e_rdata) begin
      errors++;
      $display("FAIL %s complete pulse,mem_req=%b rdata=%h want 10 %h", name,
               {got_pulse, mem_req}, got_rdata, e_rdata);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({if_rvalid, d_done, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL %s after pulses got %b want 000", name, {if_rvalid, d_done, mem_req});
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({if_rvalid, if_rdata, d_done, d_rdata, stall_if, stall_mem, mem_req, mem_we,
         mem_addr, mem_be, mem_wdata, err} !== '0) begin
      errors++;
      $display("FAIL reset outputs not all zero: rv=%b dd=%b req=%b we=%b addr=%h be=%b err=%b",
               if_rvalid, d_done, mem_req, mem_we, mem_addr, mem_be, err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    do_access("fetch", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 2'b00, 2'b00, 1'b0, 32'h0010_0093, 2);
    do_access("fetch_ready_at_grant", 1'b1, 1'b0, 32'h0000_0016, 32'h0, 2'b00, 2'b00, 1'b0,
              32'hCAFE_F00D, 0);
  endtask

  task automatic test_stores();
    do_access("sb", 1'b0, 1'b1, 32'h0000_0103, 32'h0000_00AB, 2'b11, 2'b00, 1'b0, 32'h0, 1);
    do_access("sh", 1'b0, 1'b1, 32'h0000_0107, 32'h1234_5678, 2'b10, 2'b00, 1'b0, 32'h0, 0);
    do_access("sw", 1'b0, 1'b1, 32'h0000_0208, 32'h0BAD_F00D, 2'b01, 2'b00, 1'b0, 32'h0, 1);
    do_access("swhb00", 1'b0, 1'b1, 32'h0000_020C, 32'h1111_2222, 2'b00, 2'b00, 1'b0, 32'h0, 0);
  endtask

  task automatic test_loads();
    do_access("lh", 1'b0, 1'b0, 32'h0000_0002, 32'h0, 2'b00, 2'b01, 1'b0, 32'h80F0_7F01, 1);
    do_access("lbu", 1'b0, 1'b0, 32'h0000_0001, 32'h0, 2'b00, 2'b10, 1'b1, 32'h80F0_7F01, 0);
    do_access("lb", 1'b0, 1'b0, 32'h0000_0003, 32'h0, 2'b00, 2'b10, 1'b0, 32'h80F0_7F01, 2);
    do_access("lw11", 1'b0, 1'b0, 32'h0000_0003, 32'h0, 2'b00, 2'b11, 1'b0, 32'h80F0_7F01, 0);
  endtask

  task automatic test_simultaneous();
    int budget;
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_swhb = 2'b01;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !==
        {1'b1, 1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL sim data_first req=%b we=%b addr=%h be=%b wdata=%h want 1 1 100 1111 deadbeef",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    checks++;
    if ({stall_if, stall_mem} !== 2'b11) begin
      errors++;
      $display("FAIL sim wait stalls got %b want 11", {stall_if, stall_mem});
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({stall_if, stall_mem} !== 2'b10) begin
      errors++;
      $display("FAIL sim ready stalls got %b want 10", {stall_if, stall_mem});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({d_done, if_rvalid, d_rdata, stall_if} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL sim data_done dd=%b rv=%b rdata=%h stall_if=%b want 1 0 0 1",
               d_done, if_rvalid, d_rdata, stall_if);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    budget = 0;
    @(negedge clk);
    #1;
    while (!mem_req && budget < 5) begin
      checks++;
      if (stall_if !== 1'b1) begin
        errors++;
        $display("FAIL sim fetch_wait stall_if got %b want 1", stall_if);
      end
      @(negedge clk);
      #1;
      budget++;
    end
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h0000_0040, 4'hF}) begin
      errors++;
      $display("FAIL sim fetch_grant req=%b we=%b addr=%h be=%b want 1 0 40 1111",
               mem_req, mem_we, mem_addr, mem_be);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0013;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h0000_0013}) begin
      errors++;
      $display("FAIL sim fetch_done rv=%b rdata=%h want 1 00000013", if_rvalid, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    int   kind, lat;
    logic [31:0] a, w, word;
    logic [1:0]  sw, lw;
    bit   uns;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 2);
      lat  = $urandom_range(0, 3);
      a    = $urandom;
      w    = $urandom;
      word = $urandom;
      sw   = 2'($urandom_range(0, 3));
      lw   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      do_access($sformatf("rand%0d_k%0d", i, kind), kind == 0, kind == 2, a, w, sw, lw, uns,
                word, lat);
    end
  endtask

  // Both requesters held; memory answers as soon as it is asked.
  task automatic run_both(input string name, input int n, input int cnt_in, output int cnt_out);
    string got, exp;
    int    seen, cyc, cnt;
    got = ""; exp = ""; seen = 0; cyc = 0; cnt = cnt_in;
    for (int i = 0; i < n; i++) begin
      if (cnt == FAIR_LIMIT) begin
        exp = {exp, "F"};
        cnt = 0;
      end else begin
        exp = {exp, "D"};
        cnt = (cnt + 1 > FAIR_LIMIT) ? FAIR_LIMIT : cnt + 1;
      end
    end
    cnt_out = cnt;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; d_lwhb = 2'b00;
    mem_ready = 1'b0;
    while (seen < n && cyc < 10 * n) begin
      @(negedge clk);
      cyc++;
      if (if_rvalid) begin got = {got, "F"}; seen++; end
      if (d_done)    begin got = {got, "D"}; seen++; end
      mem_ready = mem_req;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s grant order got %s want %s", name, got, exp);
    end
  endtask

  task automatic test_fairness();
    int cnt;
    do_reset();
    run_both("fair_first", 12, 0, cnt);
    // A data grant with no fetch waiting clears the fairness count.
    do_access("fair_clear", 1'b0, 1'b0, 32'h0000_0200, 32'h0, 2'b00, 2'b00, 1'b0, 32'h1234_5678, 0);
    run_both("fair_after_clear", 6, 0, cnt);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0044; d_lwhb = 2'b00; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid grant mem_req got %b want 1", mem_req);
    end
    @(negedge clk);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_req, d_done, if_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid abort req,done,rv got %b want 000", {mem_req, d_done, if_rvalid});
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if ({mem_req, d_done} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid after req,done got %b want 00", {mem_req, d_done});
      end
    end
  endtask

  task automatic test_idle_ready();
    repeat (4) begin
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      #1;
      checks++;
      if ({mem_req, if_rvalid, d_done, err} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_ready req,rv,done,err got %b want 0000",
                 {mem_req, if_rvalid, d_done, err});
      end
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_swhb = 2'b00; d_lwhb = 2'b00; d_lunsigned = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_fetch();
    test_stores();
    test_loads();
    test_simultaneous();
    test_random(30);
    test_fairness();
    test_reset_mid();
    test_idle_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
